hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard/stall controller for the 5-stage MIPS core.
//  - Detects RAW hazards between the ID-stage sources and the EXE/MEM destinations.
//  - Sequences multi-cycle data-memory waits and masks branch flushes while the pipe is held.
//  - Sits beside forwarding_EXE; drives PC/IF-ID freeze, ID-EXE bubble, whole-pipe freeze and IF flush.
// PARAMETERS
//  ADDR_LEN     5   register-file address width (`REG_FILE_ADDR_LEN)
//  MEM_TIMEOUT  64  max MEM_WAIT cycles before fatal error (>=1)
//  STALL_CNT_W  16  width of stall-cycle performance counter
// PORTS
//  clk          in   1            rising-edge clock
//  rst          in   1            async active-low reset
//  src1_ID      in   ADDR_LEN     ID-stage source 1
//  src2_ID      in   ADDR_LEN     ID-stage source 2
//  two_src_ID   in   1            ID instr reads src2 (R-type, store, branch)
//  br_taken_ID  in   1            branch resolved taken in ID
//  dest_EXE     in   ADDR_LEN     EXE-stage destination
//  WB_EN_EXE    in   1            EXE instr writes back
//  MEM_R_EN_EXE in   1            EXE instr is a load
//  dest_MEM     in   ADDR_LEN     MEM-stage destination
//  WB_EN_MEM    in   1            MEM instr writes back
//  mem_req      in   1            MEM stage has an access in flight
//  mem_ready    in   1            data memory completes access this cycle
//  hazard_stall out  1            freeze PC + IF/ID, bubble ID/EXE
//  pipe_freeze  out  1            freeze all pipeline registers
//  flush_IF     out  1            squash IF/ID (taken branch)
//  mem_err      out  1            sticky memory-timeout error
//  stall_cnt    out  STALL_CNT_W  stall-cycle count, saturating
// BEHAVIOUR
//  - Reset (rst=0, async):
//    - state=RUN; wait_cnt, stall_cnt, mem_err = 0.
//    - All outputs forced 0 while rst=0.
//  - Register 0 never creates a hazard; src2 is compared only when two_src_ID=1.
//  - raw_hit: hazard condition (see CONFIGURATION).
//  - States: RUN, MEM_WAIT, ERR (2-bit encoding).
//  - RUN:
//    - pipe_freeze  = mem_req & ~mem_ready (combinational, same cycle).
//    - hazard_stall = raw_hit & ~pipe_freeze.
//    - flush_IF     = br_taken_ID & ~pipe_freeze & ~hazard_stall.
//    - mem_req & ~mem_ready -> MEM_WAIT, wait_cnt = 1.
//  - MEM_WAIT:
//    - Outputs follow the RUN equations.
//    - mem_ready=1 -> RUN, wait_cnt=0; pipe_freeze drops in that cycle.
//    - Else if wait_cnt==MEM_TIMEOUT -> ERR, mem_err=1.
//    - Else wait_cnt++.
//  - ERR:
//    - pipe_freeze=1, hazard_stall=0, flush_IF=0.
//    - Exit only via reset.
//  - Priority: pipe_freeze > hazard_stall > flush_IF. A branch seen under stall is not lost: ID is held and re-evaluated.
//  - stall_cnt: +1 each cycle with pipe_freeze|hazard_stall; holds at 2^STALL_CNT_W-1.
//  - mem_ready without mem_req: ignored.
// CONFIGURATION
//  HAZARD_FORWARDING_EN defined (forwarding unit present):
//    - raw_hit only on load-use: WB_EN_EXE & MEM_R_EN_EXE & dest_EXE matches a used src.
//  HAZARD_FORWARDING_EN undefined:
//    - raw_hit on any match with (WB_EN_EXE, dest_EXE) or (WB_EN_MEM, dest_MEM).
// STRUCTURE
//  - defines.v: REG_FILE_ADDR_LEN, HZ_ST_RUN / HZ_ST_MEM_WAIT / HZ_ST_ERR encodings.
//  - Sub-module hazard_detect: combinational raw_hit compare, ifdef'd on HAZARD_FORWARDING_EN.
//  - Top: FSM, wait counter, stall counter.
// TESTING
//  1 Load r3 in EXE, ID reads src1=r3 (fwd build) -> hazard_stall=1 for 1 cycle; stall_cnt=1.
//  2 ALU writes r4 in MEM, ID src2=r4, two_src_ID=1:
//    - fwd build -> no stall.
//    - non-fwd build -> hazard_stall=1.
//  3 mem_req=1, mem_ready low 3 cycles then high:
//    - pipe_freeze=1 for 3 cycles, 0 on the ready cycle; state back to RUN.
//  4 MEM_TIMEOUT=4, mem_ready never rises:
//    - ERR after 4 wait cycles; mem_err=1; pipe_freeze stuck at 1 until rst=0.
//  5 br_taken_ID=1 with load-use hazard -> flush_IF=0 that cycle, 1 the next.
//  6 rst pulsed low mid MEM_WAIT -> outputs 0 immediately; RUN and counters 0 after release.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard/stall controller: register-file address width,
// FSM state encodings and default sizing.
package hazard_ctrl_pkg;

    localparam int REG_FILE_ADDR_LEN   = 5;
    localparam int DEF_MEM_TIMEOUT     = 64;
    localparam int DEF_STALL_CNT_W     = 16;

    typedef enum logic [1:0] {
        HZ_ST_RUN      = 2'b00,
        HZ_ST_MEM_WAIT = 2'b01,
        HZ_ST_ERR      = 2'b10
    } hz_state_e;

endpackage : hazard_ctrl_pkg

// File: rtl/hazard_detect.sv
// Combinational RAW compare between ID sources and EXE/MEM destinations.
// HAZARD_FORWARDING_EN selects load-use-only detection (forwarding unit present).
module hazard_detect
    import hazard_ctrl_pkg::*;
#(
    parameter int ADDR_LEN = REG_FILE_ADDR_LEN
) (
    input  logic [ADDR_LEN-1:0] src1_ID,
    input  logic [ADDR_LEN-1:0] src2_ID,
    input  logic                two_src_ID,
    input  logic [ADDR_LEN-1:0] dest_EXE,
    input  logic                WB_EN_EXE,
    input  logic                MEM_R_EN_EXE,
    input  logic [ADDR_LEN-1:0] dest_MEM,
    input  logic                WB_EN_MEM,
    output logic                raw_hit
);

    // r0 is hard-wired zero, so a write to it never produces a value to wait for.
    function automatic logic producer_hit(
        input logic [ADDR_LEN-1:0] dest,
        input logic                wb_en,
        input logic [ADDR_LEN-1:0] src1,
        input logic [ADDR_LEN-1:0] src2,
        input logic                use_src2
    );
        return wb_en && (dest != '0) &&
               ((dest == src1) || (use_src2 && (dest == src2)));
    endfunction

    logic exe_hit;
    logic mem_hit;

    assign exe_hit = producer_hit(dest_EXE, WB_EN_EXE, src1_ID, src2_ID, two_src_ID);
    assign mem_hit = producer_hit(dest_MEM, WB_EN_MEM, src1_ID, src2_ID, two_src_ID);

`ifdef HAZARD_FORWARDING_EN
    // Forwarding covers every ALU result; only a load in EXE is too late to forward.
    logic unused_mem_path;
    assign unused_mem_path = mem_hit;
    assign raw_hit         = exe_hit & MEM_R_EN_EXE;
`else
    logic unused_load_flag;
    assign unused_load_flag = MEM_R_EN_EXE;
    assign raw_hit          = exe_hit | mem_hit;
`endif

endmodule : hazard_detect

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: RAW stall, memory-wait freeze with timeout, branch flush
// and a saturating stall counter. Build option: HAZARD_FORWARDING_EN (see hazard_detect).
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int ADDR_LEN    = REG_FILE_ADDR_LEN,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int STALL_CNT_W = DEF_STALL_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_LEN-1:0]    src1_ID,
    input  logic [ADDR_LEN-1:0]    src2_ID,
    input  logic                   two_src_ID,
    input  logic                   br_taken_ID,
    input  logic [ADDR_LEN-1:0]    dest_EXE,
    input  logic                   WB_EN_EXE,
    input  logic                   MEM_R_EN_EXE,
    input  logic [ADDR_LEN-1:0]    dest_MEM,
    input  logic                   WB_EN_MEM,
    input  logic                   mem_req,
    input  logic                   mem_ready,
    output logic                   hazard_stall,
    output logic                   pipe_freeze,
    output logic                   flush_IF,
    output logic                   mem_err,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int                    WAIT_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0]     WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

    hz_state_e              state;
    logic [WAIT_W-1:0]      wait_cnt;
    logic                   err_q;
    logic [STALL_CNT_W-1:0] stall_q;

    logic raw_hit;
    logic mem_busy;
    logic freeze_c;
    logic stall_c;
    logic flush_c;

    hazard_detect #(
        .ADDR_LEN (ADDR_LEN)
    ) u_detect (
        .src1_ID      (src1_ID),
        .src2_ID      (src2_ID),
        .two_src_ID   (two_src_ID),
        .dest_EXE     (dest_EXE),
        .WB_EN_EXE    (WB_EN_EXE),
        .MEM_R_EN_EXE (MEM_R_EN_EXE),
        .dest_MEM     (dest_MEM),
        .WB_EN_MEM    (WB_EN_MEM),
        .raw_hit      (raw_hit)
    );

    // mem_ready without an outstanding request carries no meaning and is masked here.
    assign mem_busy = mem_req & ~mem_ready;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        freeze_c = 1'b0;
        stall_c  = 1'b0;
        flush_c  = 1'b0;
        if (rst) begin
            if (state == HZ_ST_ERR) begin
                freeze_c = 1'b1;
            end else begin
                freeze_c = mem_busy;
                stall_c  = raw_hit & ~freeze_c;
                flush_c  = br_taken_ID & ~freeze_c & ~stall_c;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= HZ_ST_RUN;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            unique case (state)
                HZ_ST_RUN: begin
                    if (mem_busy) begin
                        state    <= HZ_ST_MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                HZ_ST_MEM_WAIT: begin
                    // A withdrawn request ends the wait just like a completed one.
                    if (!mem_busy) begin
                        state    <= HZ_ST_RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        state <= HZ_ST_ERR;
                        err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                HZ_ST_ERR: begin
                    state <= HZ_ST_ERR;
                end
                default: begin
                    state    <= HZ_ST_RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if ((freeze_c | stall_c) && (stall_q != STALL_MAX)) begin
            stall_q <= stall_q + STALL_CNT_W'(1);
        end
    end

    assign pipe_freeze  = freeze_c;
    assign hazard_stall = stall_c;
    assign flush_IF     = flush_c;
    assign mem_err      = err_q;
    assign stall_cnt    = stall_q;

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vectors, a rule-level reference model
// checked every cycle, and hand-computed literal expectations.
module tb_hazard_ctrl;

    localparam int ADDR_LEN    = 5;
    localparam int MEM_TIMEOUT = 4;
    localparam int STALL_CNT_W = 4;
    localparam int STALL_MAX   = (1 << STALL_CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [ADDR_LEN-1:0]    src1_ID = '0;
    logic [ADDR_LEN-1:0]    src2_ID = '0;
    logic                   two_src_ID = 1'b0;
    logic                   br_taken_ID = 1'b0;
    logic [ADDR_LEN-1:0]    dest_EXE = '0;
    logic                   WB_EN_EXE = 1'b0;
    logic                   MEM_R_EN_EXE = 1'b0;
    logic [ADDR_LEN-1:0]    dest_MEM = '0;
    logic                   WB_EN_MEM = 1'b0;
    logic                   mem_req = 1'b0;
    logic                   mem_ready = 1'b0;
    logic                   hazard_stall;
    logic                   pipe_freeze;
    logic                   flush_IF;
    logic                   mem_err;
    logic [STALL_CNT_W-1:0] stall_cnt;

    hazard_ctrl #(
        .ADDR_LEN    (ADDR_LEN),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .STALL_CNT_W (STALL_CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .src1_ID      (src1_ID),
        .src2_ID      (src2_ID),
        .two_src_ID   (two_src_ID),
        .br_taken_ID  (br_taken_ID),
        .dest_EXE     (dest_EXE),
        .WB_EN_EXE    (WB_EN_EXE),
        .MEM_R_EN_EXE (MEM_R_EN_EXE),
        .dest_MEM     (dest_MEM),
        .WB_EN_MEM    (WB_EN_MEM),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .hazard_stall (hazard_stall),
        .pipe_freeze  (pipe_freeze),
        .flush_IF     (flush_IF),
        .mem_err      (mem_err),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: error flag, length of the current unbroken memory-wait run, stall total.
    bit m_err       = 1'b0;
    int m_wait_run  = 0;
    int m_stalls    = 0;

    function automatic bit producer_hits(input logic [ADDR_LEN-1:0] dest, input logic we,
                                         input logic [ADDR_LEN-1:0] s1, input logic [ADDR_LEN-1:0] s2,
                                         input logic use2);
        if (!we || dest == '0) return 1'b0;
        return (dest == s1) || (use2 && dest == s2);
    endfunction

    function automatic bit exp_raw();
`ifdef HAZARD_FORWARDING_EN
        return MEM_R_EN_EXE && producer_hits(dest_EXE, WB_EN_EXE, src1_ID, src2_ID, two_src_ID);
`else
        return producer_hits(dest_EXE, WB_EN_EXE, src1_ID, src2_ID, two_src_ID) ||
               producer_hits(dest_MEM, WB_EN_MEM, src1_ID, src2_ID, two_src_ID);
`endif
    endfunction

    function automatic bit exp_freeze();
        if (!rst) return 1'b0;
        return m_err || (mem_req && !mem_ready);
    endfunction

    function automatic bit exp_stall();
        if (!rst) return 1'b0;
        return !exp_freeze() && exp_raw();
    endfunction

    function automatic bit exp_flush();
        if (!rst) return 1'b0;
        return br_taken_ID && !exp_freeze() && !exp_stall();
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_err      = 1'b0;
            m_wait_run = 0;
            m_stalls   = 0;
        end else begin
            if (exp_freeze() || exp_stall())
                m_stalls = (m_stalls < STALL_MAX) ? m_stalls + 1 : STALL_MAX;
            if (!m_err && mem_req && !mem_ready) begin
                m_wait_run++;
                if (m_wait_run > MEM_TIMEOUT) m_err = 1'b1;
            end else begin
                m_wait_run = 0;
            end
        end
    end

    always @(negedge clk) begin
        check("model_pipe_freeze",  32'(pipe_freeze),  32'(exp_freeze()));
        check("model_hazard_stall", 32'(hazard_stall), 32'(exp_stall()));
        check("model_flush_IF",     32'(flush_IF),     32'(exp_flush()));
        check("model_mem_err",      32'(mem_err),      32'(m_err));
        check("model_stall_cnt",    32'(stall_cnt),    32'(m_stalls));
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_pipe();
        src1_ID = '0; src2_ID = '0; two_src_ID = 1'b0; br_taken_ID = 1'b0;
        dest_EXE = '0; WB_EN_EXE = 1'b0; MEM_R_EN_EXE = 1'b0;
        dest_MEM = '0; WB_EN_MEM = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic load_in_exe(input logic [ADDR_LEN-1:0] r);
        dest_EXE = r; WB_EN_EXE = 1'b1; MEM_R_EN_EXE = 1'b1;
    endtask

    initial begin
        repeat (2) sample();
        check("reset_freeze", 32'(pipe_freeze), 32'd0);
        check("reset_cnt",    32'(stall_cnt),   32'd0);
        next_cycle();
        rst = 1'b1;

        // Load-use on src1: one stall cycle, then the bubble clears EXE.
        next_cycle(); load_in_exe(5'd3); src1_ID = 5'd3;
        sample(); check("t1_stall", 32'(hazard_stall), 32'd1);
        next_cycle(); clear_pipe(); src1_ID = 5'd3;
        sample(); check("t1_released", 32'(hazard_stall), 32'd0);
        check("t1_stall_cnt", 32'(stall_cnt), 32'd1);

        // ALU result in MEM feeding src2.
        next_cycle(); clear_pipe(); dest_MEM = 5'd4; WB_EN_MEM = 1'b1;
        src1_ID = 5'd7; src2_ID = 5'd4; two_src_ID = 1'b1;
        sample();
`ifdef HAZARD_FORWARDING_EN
        check("t2_mem_fwd", 32'(hazard_stall), 32'd0);
`else
        check("t2_mem_nofwd", 32'(hazard_stall), 32'd1);
`endif
        next_cycle(); two_src_ID = 1'b0;
        sample(); check("t2_src2_unused", 32'(hazard_stall), 32'd0);
        next_cycle(); clear_pipe(); load_in_exe(5'd0);
        sample(); check("t2_reg0", 32'(hazard_stall), 32'd0);

        // Branch under load-use stall is held and flushed the next cycle.
        next_cycle(); clear_pipe(); load_in_exe(5'd5); src1_ID = 5'd5; br_taken_ID = 1'b1;
        sample(); check("t5_flush_masked", 32'(flush_IF), 32'd0);
        check("t5_stall", 32'(hazard_stall), 32'd1);
        next_cycle(); clear_pipe(); src1_ID = 5'd5; br_taken_ID = 1'b1;
        sample(); check("t5_flush", 32'(flush_IF), 32'd1);

        // Memory wait of 3 cycles; hazard and branch are masked by the freeze.
        next_cycle(); clear_pipe(); mem_req = 1'b1;
        load_in_exe(5'd6); src1_ID = 5'd6; br_taken_ID = 1'b1;
        sample(); check("t3_freeze0", 32'(pipe_freeze), 32'd1);
        check("t3_no_stall", 32'(hazard_stall), 32'd0);
        check("t3_no_flush", 32'(flush_IF), 32'd0);
        for (int i = 1; i < 3; i++) begin
            next_cycle();
            sample(); check("t3_freeze", 32'(pipe_freeze), 32'd1);
        end
        next_cycle(); clear_pipe(); mem_req = 1'b1; mem_ready = 1'b1;
        sample(); check("t3_ready", 32'(pipe_freeze), 32'd0);
        next_cycle(); clear_pipe(); mem_ready = 1'b1;
        sample(); check("t3_ready_no_req", 32'(pipe_freeze), 32'd0);

        // Timeout: MEM_TIMEOUT=4 -> ERR after the fifth frozen cycle; freeze sticks.
        next_cycle(); clear_pipe(); mem_req = 1'b1;
        sample(); check("t4_freeze_c0", 32'(pipe_freeze), 32'd1);
        for (int i = 1; i <= MEM_TIMEOUT; i++) begin
            next_cycle();
            sample(); check("t4_freeze", 32'(pipe_freeze), 32'd1);
            check("t4_err_not_early", 32'(mem_err), 32'd0);
        end
        next_cycle(); clear_pipe(); load_in_exe(5'd2); src1_ID = 5'd2; br_taken_ID = 1'b1;
        sample(); check("t4_err", 32'(mem_err), 32'd1);
        check("t4_stuck", 32'(pipe_freeze), 32'd1);
        check("t4_no_stall", 32'(hazard_stall), 32'd0);
        check("t4_no_flush", 32'(flush_IF), 32'd0);
        repeat (12) next_cycle();
        sample(); check("t4_still_stuck", 32'(pipe_freeze), 32'd1);
        check("t4_cnt_saturated", 32'(stall_cnt), 32'(STALL_MAX));

        // Reset out of ERR, then reset pulsed in the middle of a memory wait.
        #1 rst = 1'b0;
        #1 check("t6_err_reset", 32'(mem_err), 32'd0);
        next_cycle(); clear_pipe(); rst = 1'b1;
        next_cycle(); mem_req = 1'b1;
        next_cycle();
        sample();
        #1 rst = 1'b0;
        #1 check("t6_freeze_off", 32'(pipe_freeze), 32'd0);
        check("t6_cnt_zero", 32'(stall_cnt), 32'd0);
        next_cycle();
        next_cycle(); clear_pipe(); rst = 1'b1;
        sample(); check("t6_run_freeze", 32'(pipe_freeze), 32'd0);
        check("t6_run_err", 32'(mem_err), 32'd0);
        check("t6_run_cnt", 32'(stall_cnt), 32'd0);
        next_cycle(); mem_req = 1'b1;
        sample(); check("t6_new_wait", 32'(pipe_freeze), 32'd1);
        next_cycle(); mem_ready = 1'b1;
        sample(); check("t6_done", 32'(pipe_freeze), 32'd0);
        check("t6_cnt_one", 32'(stall_cnt), 32'd1);

        next_cycle(); clear_pipe();
        sample();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_hazard_ctrl
